// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: default sizes, operand and
// register-address types, and the hardwired-zero register index.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    // Register 0 always reads as zero and ignores writes
    localparam int ZERO_REG = 0;

    typedef logic [DEFAULT_AW-1:0]    reg_addr_t;
    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/alu_regfile_rdport.sv
// One synchronous read port of the register file: zero-register force,
// optional write-first bypass and the registered operand output.
// Build option: ALU_REGFILE_BYPASS_EN selects write-first behaviour for a
// same-cycle read and write of the same non-zero register; without it the
// read returns the old contents.
module alu_regfile_rdport
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] q
);

`ifdef ALU_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] next_s;
    logic             is_zero_s;
    logic             hit_s;

    assign is_zero_s = (ra == AW'(ZERO_REG));
    assign hit_s     = BYPASS && we && (wa == ra);

    // Select the value this port captures at the next edge; hold when idle
    always_comb begin
        next_s = q;
        if (rd_en) begin
            if (is_zero_s) begin
                next_s = {WIDTH{1'b0}};
            end else if (hit_s) begin
                next_s = wd;
            end else begin
                next_s = mem_data;
            end
        end else begin
            next_s = q;
        end
    end

    // Operand output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= next_s;
        end
    end

endmodule

// File: rtl/alu_regfile.sv
// Register file feeding the ALU operand buses: one write port, two
// registered read ports with one-cycle latency and an operand-valid flag.
// Build option: ALU_REGFILE_BYPASS_EN (see alu_regfile_rdport).
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             ab_valid
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_s;

    // Writes to register 0 are dropped so it stays zero
    assign wr_s = we && (wa != AW'(ZERO_REG));

    // Storage array: cleared by reset, one write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (wr_s) begin
                mem_r[wa] <= wd;
            end
        end
    end

    // Operand-valid flag follows the previous cycle's read request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_valid <= 1'b0;
        end else begin
            ab_valid <= rd_en;
        end
    end

    alu_regfile_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .ra       (ra1),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .mem_data (mem_r[ra1]),
        .q        (A)
    );

    alu_regfile_rdport #(.WIDTH(WIDTH), .AW(AW)) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .ra       (ra2),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .mem_data (mem_r[ra2]),
        .q        (B)
    );

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Register file for the single-issue datapath, sitting directly upstream of `alu`. It holds the general-purpose registers and drives the ALU's `A` and `B` operand buses from two synchronous read ports, with a one-cycle read latency and an operand-valid flag. A single write port accepts the write-back result. Register 0 is hardwired to zero.

## Interface
Parameters:
- `WIDTH`, default 32: data width; must equal the ALU operand width.
- `DEPTH`, default 32: number of registers; must be a power of two, at least 2.
- `AW`, default $clog2(DEPTH): address width; derived, never overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `rd_en`, input, 1: read request; captures both read addresses this cycle.
- `ra1`, input, AW: read address for operand A.
- `ra2`, input, AW: read address for operand B.
- `we`, input, 1: write enable.
- `wa`, input, AW: write address.
- `wd`, input, WIDTH: write data.
- `A`, output, WIDTH: registered operand A, connects to `alu.A`.
- `B`, output, WIDTH: registered operand B, connects to `alu.B`.
- `ab_valid`, output, 1: `A` and `B` hold the result of the previous cycle's `rd_en`.

## Operation
- Storage: DEPTH × WIDTH array. Entry 0 always reads as 0.
- Write: if `we`=1 and `wa`≠0, then `mem[wa]` is set to `wd` at the edge. A write to address 0 is silently dropped.
- Read: if `rd_en`=1, then at the edge `A` ← value(ra1), `B` ← value(ra2), and `ab_valid` ← 1.
- Read: if `rd_en`=0, then `A` and `B` hold their previous values and `ab_valid` ← 0.
- `ra1`=`ra2` is legal; both outputs get the same value.
- A read of address 0 gives 0 on that operand, even if the same cycle carries a write to 0.
- Same-cycle read and write to the same non-zero address: the result depends on `ALU_REGFILE_BYPASS_EN` (see Configuration).
- No other interaction between ports. Reads and writes to different addresses are independent.

## Timing
- Reset (async assert, `rst_n`=0):
  - every `mem` entry = 0
  - `A` = 0, `B` = 0, `ab_valid` = 0
  - takes effect immediately, with no clock required.
- Reset release is synchronous to `clk`. The first edge with `rst_n`=1 is a normal operating edge.
- Reset asserted in the middle of a read or write aborts it. Nothing from that cycle persists.
- Read latency: address at edge N produces data on `A`/`B` and `ab_valid`=1 after edge N, usable by the ALU during cycle N+1.
- Back-to-back reads (`rd_en` high on every cycle) give new operands every cycle.
- Write latency: data written at edge N is visible to a read captured at edge N+1. Same-edge visibility depends on the macro.
- Outputs are driven straight from flops, with no combinational path from inputs to outputs.

## Configuration
- Macro: `ALU_REGFILE_BYPASS_EN`.
- Defined (write-first bypass):
  - condition: `rd_en`, `we`, read address = `wa` ≠ 0, all in the same cycle.
  - effect: that operand captures `wd`.
- Undefined (read-first):
  - effect: the same-cycle read captures the old `mem` contents.
  - `wd` becomes visible one edge later.
- All other behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg`:
  - `WIDTH` default constant
  - `DEPTH` default constant
  - `reg_addr_t` typedef (logic [AW-1:0])
  - `word_t` typedef (logic [WIDTH-1:0])
  - `ZERO_REG` constant = 0
- One sub-module, `alu_regfile_rdport`: a single read port containing the address compare, bypass mux, zero-register force and output flop. It is instantiated twice, once for A and once for B.
- Storage array and write logic live in the top module.

## Test plan
- Reset with `rst_n`=0 in mid-cycle → `A`=0, `B`=0, `ab_valid`=0 without a clock edge. After release, reading `ra1`=5, `ra2`=31 → A=0, B=0.
- Write `wa`=3, `wd`='b1010, then `wa`=4, `wd`='b0111. Next cycle read `ra1`=3, `ra2`=4 → A='b1010, B='b0111, `ab_valid`=1, and the ALU driven with control 'b010 gives result='b10001.
- Write `wa`=0, `wd`=32'hFFFF_FFFF, then read `ra1`=0, `ra2`=0 → A=0, B=0.
- Same cycle: `we`=1, `wa`=7, `wd`=32'hDEAD_BEEF, `rd_en`=1, `ra1`=7, with `mem[7]`=1 beforehand:
  - with `ALU_REGFILE_BYPASS_EN`: A=32'hDEAD_BEEF
  - without it: A=1, and the next read gives 32'hDEAD_BEEF.
- `rd_en` pattern 1,0,0,1 with distinct data → `ab_valid` is 1,0,0,1 one cycle later, and `A`/`B` hold their values across the 0 cycles.
- Assert `rst_n` during the same cycle as a write `wa`=9, `wd`=42, then release and read `ra1`=9 → A=0.
